// File: rtl/uart_pixel_packer.sv
// Purpose : packs UART byte pairs (high byte first) into RGB565 pixels, buffers
//           them in a FWFT FIFO, tracks frame position and flags frame edges,
//           FIFO overflow and inter-byte timeouts.
// Latency : rx_done of the low byte in cycle t -> FIFO write at the end of t;
//           pix_valid/pix_data in t+1 when the FIFO was empty.
// Backpressure: pix_valid/pix_ready handshake; pop on pix_valid && pix_ready.
//           When full and not popping, an incoming pixel is dropped and the
//           sticky overflow flag is set.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rx_done, data_byte   one-cycle byte strobe and byte from the UART receiver
//   pix_ready            downstream accepts the head pixel
//   clr_err              clears the sticky overflow flag
//   pix_data, pix_valid  FIFO head pixel {hi_byte, lo_byte} and non-empty flag
//   frame_start/done     one-cycle pulses: first / last pixel of a frame pushed
//   resync               one-cycle pulse: half pixel discarded on timeout
//   overflow             sticky: a pixel was dropped on a full FIFO
//   fill_level           current FIFO occupancy
//
// Optional feature macro: FRAME_SYNC_EN -- when defined, every frame must be
// preceded by the header bytes 0xA5 0x5A (states SYNC0/SYNC1 ahead of HI).

module uart_pixel_packer #(
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 307200,
  parameter int TIMEOUT_CYC  = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_done,
  input  logic [7:0]                  data_byte,
  input  logic                        pix_ready,
  input  logic                        clr_err,
  output logic [15:0]                 pix_data,
  output logic                        pix_valid,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        resync,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fill_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIXELS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_HI    = 2'd0,
    ST_LO    = 2'd1,
    ST_SYNC0 = 2'd2,
    ST_SYNC1 = 2'd3
  } state_t;

`ifdef FRAME_SYNC_EN
  localparam state_t ST_RESET = ST_SYNC0;
`else
  localparam state_t ST_RESET = ST_HI;
`endif

  state_t          state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [CW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [15:0]     mem_d [FIFO_DEPTH];
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            resync_q, resync_d;
  logic            overflow_q, overflow_d;

  logic            pop;
  logic            full;
  logic            push_req;
  logic            push_acc;
  logic            last_pix;

  always_comb begin
    pop      = (fill_q != '0) && pix_ready;
    full     = (fill_q == FULL_LVL);
    push_req = (state_q == ST_LO) && rx_done;
    // A full FIFO still takes the pixel when the head leaves this same cycle.
    push_acc = push_req && (!full || pop);
    last_pix = (pix_cnt_q == LAST_PIX);
  end

  // Pack FSM: HI latches the high byte, LO forms the pixel or times out.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    tmo_d    = tmo_q;
    resync_d = 1'b0;
    case (state_q)
      ST_HI: begin
        if (rx_done) begin
          hi_d    = data_byte;
          tmo_d   = '0;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        // rx_done takes priority over an expiring timeout.
        if (rx_done) begin
`ifdef FRAME_SYNC_EN
          state_d = last_pix ? ST_SYNC0 : ST_HI;
`else
          state_d = ST_HI;
`endif
        end else if (tmo_q == TMO_LAST) begin
          state_d  = ST_HI;
          resync_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef FRAME_SYNC_EN
      ST_SYNC0: begin
        if (rx_done && (data_byte == 8'hA5)) state_d = ST_SYNC1;
      end
      ST_SYNC1: begin
        if (rx_done) begin
          if (data_byte == 8'h5A)      state_d = ST_HI;
          else if (data_byte != 8'hA5) state_d = ST_SYNC0;
        end
      end
`endif
      default: state_d = ST_HI;
    endcase
  end

  // Frame position counts every issued pixel, dropped ones included, so a
  // dropped pixel never shifts the frame alignment.
  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    if (push_req) begin
      frame_start_d = (pix_cnt_q == '0);
      frame_done_d  = last_pix;
      pix_cnt_d     = last_pix ? '0 : pix_cnt_q + 1'b1;
    end
    // A fresh drop outranks a clear arriving in the same cycle.
    if (push_req && !push_acc) overflow_d = 1'b1;
    else if (clr_err)          overflow_d = 1'b0;
    else                       overflow_d = overflow_q;
  end

  // FWFT FIFO: pointers wrap naturally since FIFO_DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = {hi_q, data_byte};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    fill_d = fill_q + (AW + 1)'(push_acc) - (AW + 1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RESET;
      hi_q          <= '0;
      tmo_q         <= '0;
      pix_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      resync_q      <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      tmo_q         <= tmo_d;
      pix_cnt_q     <= pix_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      resync_q      <= resync_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible through valid pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pix_valid   = (fill_q != '0);
  assign pix_data    = pix_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign fill_level  = fill_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign resync      = resync_q;
  assign overflow    = overflow_q;

endmodule
